// File: rtl/dog_anim_ctrl_if.sv
// Bus bundle between the dog sprite controller and its VGA timing, sprite ROM and palette.
// The master side drives coordinates, pacing pulses, ROM data and palette colour.
interface dog_anim_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              frame_start;
  logic              anim_en;
  logic              anim_restart;
  logic [9:0]        dog_x;
  logic [9:0]        dog_y;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        frame_sel;
  logic [3:0]        rom_index;
  logic [3:0]        pal_index;
  logic [3:0]        pal_r;
  logic [3:0]        pal_g;
  logic [3:0]        pal_b;
  logic              pix_on;
  logic [3:0]        pix_r;
  logic [3:0]        pix_g;
  logic [3:0]        pix_b;

  modport master (
    output frame_start, anim_en, anim_restart, dog_x, dog_y, draw_x, draw_y,
           rom_index, pal_r, pal_g, pal_b,
    input  rom_addr, frame_sel, pal_index, pix_on, pix_r, pix_g, pix_b
  );

  modport slave (
    input  frame_start, anim_en, anim_restart, dog_x, dog_y, draw_x, draw_y,
           rom_index, pal_r, pal_g, pal_b,
    output rom_addr, frame_sel, pal_index, pix_on, pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/dog_anim_ctrl.sv
// Dog sprite animation sequencer (vsync-paced frame stepping) and 3-stage pixel pipeline
// from draw coordinate to ROM address, palette lookup and registered RGB / pix_on.
//
//  state | meaning
//  IDLE  | not animating, frame 0 and tick count forced to 0
//  RUN   | counting frame_start pulses, stepping frame_sel every FRAME_TICKS pulses
//  PAUSE | frame_sel and tick count frozen until anim_en returns
module dog_anim_ctrl #(
  parameter int          NUM_FRAMES  = 6,
  parameter int          FRAME_TICKS = 8,
  parameter int          SPRITE_W    = 64,
  parameter int          SPRITE_H    = 64,
  parameter int          ADDR_W      = 12,
  parameter logic [15:0] TRANS_MASK  = 16'hFDAE
) (
  input  logic         Clk,
  input  logic         Reset_n,
  dog_anim_ctrl_if.slave bus
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = ADDR_W - XW;
  localparam logic [TW-1:0]     TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [2:0]        FRAME_LAST = 3'(NUM_FRAMES - 1);
  localparam logic signed [10:0] LIM_W     = 11'(SPRITE_W);
  localparam logic signed [10:0] LIM_H     = 11'(SPRITE_H);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [2:0]        frame_sel;

  logic signed [10:0] off_x, off_y;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] rom_addr;
  logic              in_box_d1, in_box_d2;
  logic              pix_on_next;
  logic              pix_on;
  logic [3:0]        pix_r, pix_g, pix_b;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      frame_sel <= '0;
    end else if (bus.anim_restart) begin
      // restart wins over a coincident frame_start
      tick_cnt  <= '0;
      frame_sel <= '0;
      state     <= bus.anim_en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt  <= '0;
          frame_sel <= '0;
          if (bus.anim_en) state <= RUN;
        end
        RUN: begin
          if (!bus.anim_en) begin
            state <= PAUSE;
          end else if (bus.frame_start) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              frame_sel <= (frame_sel == FRAME_LAST) ? 3'd0 : frame_sel + 3'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (bus.anim_en) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 11-bit signed offsets so a sprite wrapped past a screen edge reads as negative
  assign off_x  = $signed({1'b0, bus.draw_x}) - $signed({1'b0, bus.dog_x});
  assign off_y  = $signed({1'b0, bus.draw_y}) - $signed({1'b0, bus.dog_y});
  assign in_box = !off_x[10] && !off_y[10] && (off_x < LIM_W) && (off_y < LIM_H);
  assign addr_next = in_box ? {off_y[YW-1:0], off_x[XW-1:0]} : '0;

  assign bus.pal_index = bus.rom_index;
  assign pix_on_next   = in_box_d2 & ~TRANS_MASK[bus.rom_index];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
      pix_on    <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else begin
      rom_addr  <= addr_next;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
      pix_on    <= pix_on_next;
      pix_r     <= pix_on_next ? bus.pal_r : 4'd0;
      pix_g     <= pix_on_next ? bus.pal_g : 4'd0;
      pix_b     <= pix_on_next ? bus.pal_b : 4'd0;
    end
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.frame_sel = frame_sel;
  assign bus.pix_on    = pix_on;
  assign bus.pix_r     = pix_r;
  assign bus.pix_g     = pix_g;
  assign bus.pix_b     = pix_b;

endmodule

// File: tb/tb_dog_anim_ctrl.sv
// Self-checking bench for dog_anim_ctrl: vector table, directed animation sequences and
// randomized animation / pixel traffic against a pulse-count and coordinate-arithmetic model.
module tb_dog_anim_ctrl;

  localparam logic [15:0] MASK = 16'hFDAE;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  dog_anim_ctrl_if #(.ADDR_W(12)) bus ();

  dog_anim_ctrl #(
    .NUM_FRAMES(6), .FRAME_TICKS(8), .SPRITE_W(64), .SPRITE_H(64),
    .ADDR_W(12), .TRANS_MASK(MASK)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus.slave)
  );

  // sprite ROM (synchronous) and palette (combinational) models
  logic [3:0] rom_mem [4096];
  always @(posedge Clk) bus.rom_index <= rom_mem[bus.rom_addr];
  assign bus.pal_r = bus.pal_index + 4'd1;
  assign bus.pal_g = bus.pal_index >> 1;
  assign bus.pal_b = {bus.pal_index[1:0], 2'b00};

  int total = 0;
  int bad   = 0;

  // animation model: counted pulses since restart; frame = (count / 8) mod 6
  int  m_cnt    = 0;
  bit  m_active = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pal_rgb(int i);
    pal_rgb = {4'((i + 1) % 16), 4'(i / 2), 4'((i * 4) % 16)};
  endfunction

  task automatic cyc(bit fs, bit en, bit rs);
    bus.frame_start  = fs;
    bus.anim_en      = en;
    bus.anim_restart = rs;
    if (rs) m_cnt = 0;
    else if (m_active && en && fs) m_cnt++;
    m_active = en;
    @(negedge Clk);
    check("frame_sel_model", bus.frame_sel, (m_cnt / 8) % 6);
  endtask

  task automatic pulse(int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
  endtask

  typedef struct {
    logic [9:0]  dx, dy, wx, wy;
    logic [3:0]  rv;
    logic [11:0] ea;
    logic        eo;
    logic [11:0] ergb;
  } vec_t;

  vec_t vt [9];

  typedef struct {
    logic        on;
    logic [11:0] rgb;
  } pexp_t;

  pexp_t pq [$];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{10'd100, 10'd50, 10'd101, 10'd50, 4'd4, 12'd1,    1'b1, 12'h520};
    vt[1] = '{10'd100, 10'd50, 10'd101, 10'd50, 4'd1, 12'd1,    1'b0, 12'h000};
    vt[2] = '{10'd600, 10'd50, 10'd5,   10'd60, 4'd4, 12'd0,    1'b0, 12'h000};
    vt[3] = '{10'd0,   10'd0,  10'd63,  10'd63, 4'd9, 12'd4095, 1'b1, 12'hA44};
    vt[4] = '{10'd0,   10'd0,  10'd64,  10'd0,  4'd4, 12'd0,    1'b0, 12'h000};
    vt[5] = '{10'd10,  10'd10, 10'd9,   10'd10, 4'd4, 12'd0,    1'b0, 12'h000};
    vt[6] = '{10'd1000,10'd1000,10'd1010,10'd1003,4'd6,12'd202, 1'b1, 12'h738};
    vt[7] = '{10'd1020,10'd0,  10'd2,   10'd0,  4'd4, 12'd0,    1'b0, 12'h000};
    vt[8] = '{10'd5,   10'd5,  10'd5,   10'd5,  4'd0, 12'd0,    1'b1, 12'h100};

    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));

    bus.frame_start = 0; bus.anim_en = 0; bus.anim_restart = 0;
    bus.dog_x = 0; bus.dog_y = 0; bus.draw_x = 700; bus.draw_y = 700;

    repeat (3) @(negedge Clk);
    check("reset_frame_sel", bus.frame_sel, 0);
    check("reset_pix_on", bus.pix_on, 0);
    check("reset_rgb", {bus.pix_r, bus.pix_g, bus.pix_b}, 0);
    check("reset_rom_addr", bus.rom_addr, 0);
    Reset_n = 1;

    // vector table: one pixel point at a time, inputs held across the pipeline
    for (int i = 0; i < 9; i++) begin
      bus.dog_x = vt[i].dx; bus.dog_y = vt[i].dy;
      bus.draw_x = vt[i].wx; bus.draw_y = vt[i].wy;
      rom_mem[vt[i].ea] = vt[i].rv;
      @(negedge Clk);
      check("vec_rom_addr", bus.rom_addr, vt[i].ea);
      repeat (2) @(negedge Clk);
      check("vec_pix_on", bus.pix_on, vt[i].eo);
      check("vec_rgb", {bus.pix_r, bus.pix_g, bus.pix_b}, vt[i].ergb);
    end

    // frame stepping and wrap
    cyc(0, 1, 1);
    pulse(7);
    check("step_before_8th", bus.frame_sel, 0);
    pulse(1);
    check("step_on_8th", bus.frame_sel, 1);
    pulse(40);
    check("wrap_after_48", bus.frame_sel, 0);

    // pause holds tick count, resume continues from it
    cyc(0, 1, 1);
    pulse(5);
    cyc(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    check("pause_hold", bus.frame_sel, 0);
    cyc(0, 1, 0);
    pulse(2);
    check("resume_tick7", bus.frame_sel, 0);
    pulse(1);
    check("resume_advance", bus.frame_sel, 1);

    // restart coincident with the would-be advancing pulse
    cyc(0, 1, 1);
    pulse(7);
    cyc(1, 1, 1);
    check("restart_wins", bus.frame_sel, 0);
    pulse(7);
    check("restart_tick_cleared", bus.frame_sel, 0);
    pulse(1);
    check("restart_then_8", bus.frame_sel, 1);

    // asynchronous reset mid-RUN with an opaque pixel on screen
    cyc(0, 1, 1);
    pulse(24);
    check("pre_reset_frame3", bus.frame_sel, 3);
    bus.dog_x = 100; bus.dog_y = 50; bus.draw_x = 101; bus.draw_y = 50;
    rom_mem[1] = 4'd4;
    repeat (3) @(negedge Clk);
    check("pre_reset_pix_on", bus.pix_on, 1);
    @(posedge Clk);
    #2 Reset_n = 0;
    #1;
    check("async_frame_sel", bus.frame_sel, 0);
    check("async_pix_on", bus.pix_on, 0);
    check("async_rgb", {bus.pix_r, bus.pix_g, bus.pix_b}, 0);
    @(negedge Clk);
    bus.anim_en = 0; bus.frame_start = 0; bus.anim_restart = 0;
    Reset_n = 1;
    m_cnt = 0; m_active = 0;
    cyc(1, 0, 0);
    check("idle_ignores_pulse", bus.frame_sel, 0);

    // randomized animation control
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 80) == 0);
    cyc(0, 0, 0);

    // randomized pixel traffic, expectations from coordinate arithmetic
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    begin
      int    prev_addr;
      bit    have_prev;
      have_prev = 0;
      prev_addr = 0;
      for (int k = 0; k < 700; k++) begin
        int    ox, oy, addr, idx;
        bit    inb;
        pexp_t e;
        @(negedge Clk);
        if (pq.size() == 3) begin
          e = pq.pop_front();
          check("rand_pix_on", bus.pix_on, e.on);
          check("rand_rgb", {bus.pix_r, bus.pix_g, bus.pix_b}, e.rgb);
        end
        if (have_prev) check("rand_rom_addr", bus.rom_addr, prev_addr);
        bus.dog_x = 10'($urandom_range(0, 1023));
        bus.dog_y = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) begin
          bus.draw_x = 10'(int'(bus.dog_x) + int'($urandom_range(0, 72)) - 4);
          bus.draw_y = 10'(int'(bus.dog_y) + int'($urandom_range(0, 72)) - 4);
        end else begin
          bus.draw_x = 10'($urandom_range(0, 1023));
          bus.draw_y = 10'($urandom_range(0, 1023));
        end
        ox   = int'(bus.draw_x) - int'(bus.dog_x);
        oy   = int'(bus.draw_y) - int'(bus.dog_y);
        inb  = (ox >= 0) && (ox < 64) && (oy >= 0) && (oy < 64);
        addr = inb ? oy * 64 + ox : 0;
        idx  = int'(rom_mem[addr]);
        e.on  = inb && !MASK[idx];
        e.rgb = e.on ? pal_rgb(idx) : 12'h000;
        pq.push_back(e);
        prev_addr = addr;
        have_prev = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
